// File: rtl/eth_fcs_insert.sv
// eth_fcs_insert
//
// Ethernet TX framing stage. Forwards an 8-bit AXI-Stream frame (destination
// MAC through payload) unchanged, zero-pads short frames up to
// MIN_FRAME_BYTES when PAD_EN=1, and then appends the 4-byte IEEE 802.3 FCS
// (reflected CRC-32), least significant byte first. The output tlast is
// asserted only on the final FCS byte. The CRC is computed on the fly, so no
// frame buffering is needed.
//
// Parameters:
//   MIN_FRAME_BYTES  minimum pre-FCS frame length (default 60)
//   PAD_EN           1 = zero-pad short frames, 0 = FCS directly after data
//
// Ports:
//   clk            clock, all logic on the rising edge
//   sreset         synchronous reset, active-high
//   axis_i_tready  out  input ready (follows axis_o_tready while passing data)
//   axis_i_tvalid  in   input valid
//   axis_i_tlast   in   last byte of the input frame
//   axis_i_tdata   in   input byte
//   axis_o_tready  in   output ready
//   axis_o_tvalid  out  output valid (never depends on axis_o_tready)
//   axis_o_tlast   out  asserted only on the 4th FCS byte
//   axis_o_tdata   out  output byte
module eth_fcs_insert #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter bit PAD_EN          = 1'b1
) (
  input  logic       clk,
  input  logic       sreset,
  output logic       axis_i_tready,
  input  logic       axis_i_tvalid,
  input  logic       axis_i_tlast,
  input  logic [7:0] axis_i_tdata,
  input  logic       axis_o_tready,
  output logic       axis_o_tvalid,
  output logic       axis_o_tlast,
  output logic [7:0] axis_o_tdata
);

  localparam int CW = $clog2(MIN_FRAME_BYTES + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_FRAME_BYTES);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    PAD  = 2'd1,
    FCS  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next, count_inc;
  logic [31:0]   crc, crc_next, fcs;
  logic [1:0]    fcs_idx, fcs_idx_next;

  // One byte of the reflected CRC-32, data consumed LSB-first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // The count only has to reach MIN_FRAME_BYTES, so it saturates there and
  // long frames need no length limit.
  assign count_inc = (count == MIN_C) ? count : count + CW'(1);

  // The CRC register is not updated in FCS, so this value stays frozen for
  // all four FCS bytes.
  assign fcs = ~crc;

  // State, count, CRC and FCS byte index registers.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state   <= PASS;
      count   <= '0;
      crc     <= CRC_INIT;
      fcs_idx <= 2'd0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      crc     <= crc_next;
      fcs_idx <= fcs_idx_next;
    end
  end

  // Next-state logic and stream outputs. PASS is a zero-latency combinational
  // pass-through; PAD and FCS generate bytes locally with input held off.
  always_comb begin
    state_next    = state;
    count_next    = count;
    crc_next      = crc;
    fcs_idx_next  = fcs_idx;
    axis_i_tready = 1'b0;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = 8'h00;

    case (state)
      PASS: begin
        axis_i_tready = axis_o_tready;
        axis_o_tvalid = axis_i_tvalid;
        axis_o_tdata  = axis_i_tvalid ? axis_i_tdata : 8'h00;
        if (axis_i_tvalid && axis_o_tready) begin
          crc_next   = crc32_byte(crc, axis_i_tdata);
          count_next = count_inc;
          if (axis_i_tlast) begin
            state_next = (PAD_EN && (count_inc < MIN_C)) ? PAD : FCS;
          end
        end
      end

      PAD: begin
        axis_o_tvalid = 1'b1;
        if (axis_o_tready) begin
          crc_next   = crc32_byte(crc, 8'h00);
          count_next = count_inc;
          if (count_inc == MIN_C) begin
            state_next = FCS;
          end
        end
      end

      FCS: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = fcs[{fcs_idx, 3'b000} +: 8];
        axis_o_tlast  = (fcs_idx == 2'd3);
        if (axis_o_tready) begin
          if (fcs_idx == 2'd3) begin
            state_next   = PASS;
            count_next   = '0;
            crc_next     = CRC_INIT;
            fcs_idx_next = 2'd0;
          end else begin
            fcs_idx_next = fcs_idx + 2'd1;
          end
        end
      end

      default: begin
        state_next = PASS;
      end
    endcase

    // While reset is held the frame is abandoned at once: nothing is
    // accepted and nothing is presented downstream.
    if (sreset) begin
      axis_i_tready = 1'b0;
      axis_o_tvalid = 1'b0;
      axis_o_tlast  = 1'b0;
      axis_o_tdata  = 8'h00;
    end
  end

endmodule

// File: tb/tb_eth_fcs_insert.sv
// tb_eth_fcs_insert
//
// Self-checking bench for eth_fcs_insert. Two instances are used: one with
// PAD_EN=0 for the plain "123456789" check vector, one with PAD_EN=1 for the
// padding, stall, back-to-back and reset scenarios. Expected output bytes are
// pushed to a scoreboard queue when a frame is driven and popped as the
// selected DUT transfers bytes. Every completed output frame is also run
// through a CRC-32 and must leave the 802.3 residue 0xDEBB20E3.
module tb_eth_fcs_insert;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         kind;   // 0 data, 1 pad, 2 fcs
    int         flen;   // total output bytes of this frame
  } exp_t;

  logic       clk = 1'b0;
  logic       sreset;
  logic       drv_valid, drv_last;
  logic [7:0] drv_data;
  logic       out_tready = 1'b1;
  bit         use_nopad = 1'b0;

  logic       valid0, valid1;
  logic       in_tready0, in_tready1;
  logic       o_tvalid0, o_tvalid1, o_tlast0, o_tlast1;
  logic [7:0] o_tdata0, o_tdata1;

  logic       cur_in_tready, cur_o_tvalid, cur_o_tlast;
  logic [7:0] cur_o_tdata;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] frame_buf [0:127];
  bit         rand_ready = 1'b0;
  bit         check_gap = 1'b0;

  // Monitor state
  logic [31:0] mon_crc = 32'hFFFF_FFFF;
  int          mon_len = 0;
  int          ncycle = 0;
  int          last_cycle = 0;
  bit          after_last = 1'b0;
  bit          gap_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [8:0]  prev_word = 9'h0;
  exp_t        e;

  always #5 clk = ~clk;

  assign valid0 = use_nopad & drv_valid;
  assign valid1 = ~use_nopad & drv_valid;

  assign cur_in_tready = use_nopad ? in_tready0 : in_tready1;
  assign cur_o_tvalid  = use_nopad ? o_tvalid0  : o_tvalid1;
  assign cur_o_tlast   = use_nopad ? o_tlast0   : o_tlast1;
  assign cur_o_tdata   = use_nopad ? o_tdata0   : o_tdata1;

  eth_fcs_insert #(.MIN_FRAME_BYTES(60), .PAD_EN(1'b0)) dut_nopad (
    .clk           (clk),
    .sreset        (sreset),
    .axis_i_tready (in_tready0),
    .axis_i_tvalid (valid0),
    .axis_i_tlast  (drv_last),
    .axis_i_tdata  (drv_data),
    .axis_o_tready (out_tready),
    .axis_o_tvalid (o_tvalid0),
    .axis_o_tlast  (o_tlast0),
    .axis_o_tdata  (o_tdata0)
  );

  eth_fcs_insert #(.MIN_FRAME_BYTES(60), .PAD_EN(1'b1)) dut_pad (
    .clk           (clk),
    .sreset        (sreset),
    .axis_i_tready (in_tready1),
    .axis_i_tvalid (valid1),
    .axis_i_tlast  (drv_last),
    .axis_i_tdata  (drv_data),
    .axis_o_tready (out_tready),
    .axis_o_tvalid (o_tvalid1),
    .axis_o_tlast  (o_tlast1),
    .axis_o_tdata  (o_tdata1)
  );

  // Reflected CRC-32 over one byte, used to build expected FCS bytes and
  // to run the residue check over whole output frames.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Push the expected output of a frame held in frame_buf[0:len-1].
  task automatic buildExpected(input int len, input bit pad_en);
    logic [31:0] c;
    logic [31:0] f;
    int pads;
    int total;
    c     = 32'hFFFF_FFFF;
    pads  = (pad_en && len < 60) ? 60 - len : 0;
    total = len + pads + 4;
    for (int i = 0; i < len; i++) begin
      c = crc_step(c, frame_buf[i]);
      sb.push_back('{data: frame_buf[i], last: 1'b0, kind: 0, flen: total});
    end
    for (int i = 0; i < pads; i++) begin
      c = crc_step(c, 8'h00);
      sb.push_back('{data: 8'h00, last: 1'b0, kind: 1, flen: total});
    end
    c = ~c;
    for (int i = 0; i < 4; i++) begin
      f = c >> (8 * i);
      sb.push_back('{data: f[7:0], last: (i == 3), kind: 2, flen: total});
    end
  endtask

  // Drive frame_buf[0:len-1] into the selected DUT, holding each byte until
  // accepted. Called and returns at posedge+1.
  task automatic driveFrame(input int len, input bit gaps);
    bit accepted;
    int waited;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        drv_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      drv_valid = 1'b1;
      drv_data  = frame_buf[i];
      drv_last  = (i == len - 1);
      accepted  = 1'b0;
      waited    = 0;
      while (!accepted && waited < 5000) begin
        @(negedge clk);
        accepted = cur_in_tready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (!accepted) begin
        checkOutput("drive_timeout", 32'(accepted), 32'd1);
        break;
      end
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    drv_data  = 8'h00;
  endtask

  task automatic applyStimulus(input int len, input bit pad_en, input bit gaps);
    buildExpected(len, pad_en);
    driveFrame(len, gaps);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Output ready: always 1, or a 50% random pattern when enabled.
  always @(posedge clk) begin
    #1;
    out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: samples on the falling edge, where the values seen are exactly
  // those the next rising edge will transfer.
  always @(negedge clk) begin
    ncycle++;
    if (sreset) begin
      mon_crc    = 32'hFFFF_FFFF;
      mon_len    = 0;
      prev_stall = 1'b0;
      after_last = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(cur_o_tvalid), 32'd1);
        checkOutput("hold_data", 32'({cur_o_tlast, cur_o_tdata}), 32'(prev_word));
      end
      prev_stall = cur_o_tvalid && !out_tready;
      prev_word  = {cur_o_tlast, cur_o_tdata};

      if (sb.size() > 0 && sb[0].kind != 0 && cur_o_tvalid) begin
        checkOutput("in_ready_low", 32'(cur_in_tready), 32'd0);
      end

      if (cur_o_tvalid && out_tready) begin
        if (sb.size() == 0) begin
          checkOutput("extra_byte", 32'(cur_o_tvalid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("data", 32'(cur_o_tdata), 32'(e.data));
          checkOutput("last", 32'(cur_o_tlast), 32'(e.last));
        end
        mon_crc = crc_step(mon_crc, cur_o_tdata);
        mon_len++;
        if (check_gap && after_last && !gap_done) begin
          checkOutput("b2b_gap", 32'(ncycle - last_cycle), 32'd1);
          gap_done = 1'b1;
        end
        after_last = cur_o_tlast;
        if (cur_o_tlast) begin
          checkOutput("residue", mon_crc, 32'hDEBB_20E3);
          checkOutput("frame_len", 32'(mon_len), 32'(e.flen));
          last_cycle = ncycle;
          mon_crc    = 32'hFFFF_FFFF;
          mon_len    = 0;
        end
      end
    end
  end

  // Main sequence.
  initial begin
    logic [7:0] fcs_lit [0:3];
    fcs_lit[0] = 8'h26;
    fcs_lit[1] = 8'h39;
    fcs_lit[2] = 8'hF4;
    fcs_lit[3] = 8'hCB;

    // Reset with input valid: nothing must leak through.
    sreset    = 1'b1;
    drv_valid = 1'b1;
    drv_data  = 8'h55;
    drv_last  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", 32'(cur_o_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(cur_o_tlast), 32'd0);
    checkOutput("rst_tdata", 32'(cur_o_tdata), 32'd0);
    checkOutput("rst_in_ready", 32'(cur_in_tready), 32'd0);
    @(posedge clk);
    #1;
    sreset    = 1'b0;
    drv_valid = 1'b0;
    drv_data  = 8'h00;
    drv_last  = 1'b0;
    @(negedge clk);
    checkOutput("idle_tvalid", 32'(cur_o_tvalid), 32'd0);
    checkOutput("idle_tdata", 32'(cur_o_tdata), 32'd0);
    checkOutput("idle_in_ready", 32'(cur_in_tready), 32'(out_tready));
    @(posedge clk);
    #1;

    // "123456789" without padding, FCS from a literal table.
    $display("[TB] frame 123456789, PAD_EN=0");
    use_nopad = 1'b1;
    for (int i = 0; i < 9; i++) begin
      frame_buf[i] = 8'h31 + 8'(i);
      sb.push_back('{data: frame_buf[i], last: 1'b0, kind: 0, flen: 13});
    end
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{data: fcs_lit[i], last: (i == 3), kind: 2, flen: 13});
    end
    driveFrame(9, 1'b0);
    waitDrain();
    use_nopad = 1'b0;

    // 14-byte frame, padded to 60.
    $display("[TB] 14-byte frame with padding");
    for (int i = 0; i < 14; i++) frame_buf[i] = 8'(i * 7 + 3);
    applyStimulus(14, 1'b1, 1'b0);
    waitDrain();

    // Exactly-minimum and long frames: no padding.
    $display("[TB] 60-byte and 100-byte frames");
    for (int i = 0; i < 100; i++) frame_buf[i] = 8'(i * 13 + 101);
    applyStimulus(60, 1'b1, 1'b0);
    waitDrain();
    applyStimulus(100, 1'b1, 1'b0);
    waitDrain();

    // Same 14-byte frame with random stalls on both sides.
    $display("[TB] stalled 14-byte and 70-byte frames");
    rand_ready = 1'b1;
    for (int i = 0; i < 14; i++) frame_buf[i] = 8'(i * 7 + 3);
    applyStimulus(14, 1'b1, 1'b1);
    waitDrain();
    for (int i = 0; i < 70; i++) frame_buf[i] = 8'($urandom_range(0, 255));
    applyStimulus(70, 1'b1, 1'b1);
    waitDrain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back frames.
    $display("[TB] back-to-back frames");
    for (int i = 0; i < 20; i++) frame_buf[i] = 8'(i + 200);
    applyStimulus(20, 1'b1, 1'b0);
    check_gap = 1'b1;
    for (int i = 0; i < 61; i++) frame_buf[i] = 8'(i * 3 + 1);
    applyStimulus(61, 1'b1, 1'b0);
    waitDrain();
    check_gap = 1'b0;
    checkOutput("b2b_seen", 32'(gap_done), 32'd1);

    // Reset in the middle of padding, then a clean frame.
    $display("[TB] reset during padding");
    for (int i = 0; i < 9; i++) frame_buf[i] = 8'h31 + 8'(i);
    applyStimulus(9, 1'b1, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    sreset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tvalid", 32'(cur_o_tvalid), 32'd0);
    checkOutput("midrst_in_ready", 32'(cur_in_tready), 32'd0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("post_rst_tvalid", 32'(cur_o_tvalid), 32'd0);
    checkOutput("post_rst_in_ready", 32'(cur_in_tready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(9, 1'b1, 1'b0);
    waitDrain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
